// File: rtl/opb_cfg_seq_pkg.sv
// Shared types and constants for the OPB configuration sequencer.
// The command word layout is shared by the FIFO and the top-level FSM.
package opb_cfg_seq_pkg;

  localparam int AWIDTH    = 32;
  localparam int DWIDTH    = 32;
  localparam int BEWIDTH   = 4;
  localparam int CMD_WIDTH = 1 + AWIDTH + DWIDTH + BEWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ERRACK  = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
  localparam logic [1:0] STATUS_RETRY   = 2'b11;

  typedef struct packed {
    logic               rnw;
    logic [AWIDTH-1:0]  addr;
    logic [DWIDTH-1:0]  data;
    logic [BEWIDTH-1:0] be;
  } cmd_t;

endpackage

// File: rtl/opb_cfg_seq_fifo.sv
// Command FIFO: array storage with a registered head read, pointers carrying
// an extra wrap bit so full and empty can be told apart.
module opb_cfg_seq_fifo
  import opb_cfg_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_full,
  output logic             not_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_reg;
  logic [PW:0]      wr_ptr_reg, wr_ptr_next;
  logic [PW:0]      rd_ptr_reg, rd_ptr_next;
  logic             empty_reg;
  logic             not_full_reg;
  logic             do_push, do_pop;

  assign do_push = push & not_full_reg;
  assign do_pop  = pop & ~empty_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + {{PW{1'b0}}, do_push};
    rd_ptr_next = rd_ptr_reg + {{PW{1'b0}}, do_pop};
  end

  // Flags are registered from the next pointers so they are valid the cycle after a push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      empty_reg    <= 1'b1;
      not_full_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      empty_reg    <= (wr_ptr_next == rd_ptr_next);
      not_full_reg <= !((wr_ptr_next[PW] != rd_ptr_next[PW]) &&
                        (wr_ptr_next[PW-1:0] == rd_ptr_next[PW-1:0]));
    end
  end

  // Storage has no reset so it maps onto RAM; the head lags rd_ptr by one cycle.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[PW-1:0]] <= push_data;
    end
    head_reg <= mem[rd_ptr_reg[PW-1:0]];
  end

  assign head_data = head_reg;
  assign not_full  = not_full_reg;
  assign not_empty = ~empty_reg;

endmodule

// File: rtl/opb_cfg_sequencer.sv
// OPB master that replays queued single-beat configuration reads/writes,
// handling arbitration, retries, errAck and a per-attempt local timeout.
module opb_cfg_sequencer
  import opb_cfg_seq_pkg::*;
#(
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_TIMEOUT    = 16,
  parameter int C_MAX_RETRY  = 3
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rnw,
  input  logic [AWIDTH-1:0]   cmd_addr,
  input  logic [DWIDTH-1:0]   cmd_data,
  input  logic [BEWIDTH-1:0]  cmd_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DWIDTH-1:0]   rsp_data,
  output logic [1:0]          rsp_status,
  output logic                busy,
  output logic                M_request,
  output logic                M_select,
  output logic                M_RNW,
  output logic                M_seqAddr,
  output logic [0:AWIDTH-1]   M_ABus,
  output logic [0:DWIDTH-1]   M_DBus,
  output logic [0:BEWIDTH-1]  M_BE,
  input  logic                OPB_MGrant,
  input  logic                OPB_xferAck,
  input  logic                OPB_errAck,
  input  logic                OPB_retry,
  input  logic                OPB_timeout,
  input  logic [0:DWIDTH-1]   OPB_DBus
);

  localparam int TW = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT);
  localparam int RW = (C_MAX_RETRY < 1) ? 1 : $clog2(C_MAX_RETRY + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(C_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(C_MAX_RETRY);

  seq_state_e       state_reg, state_next;
  logic [RW-1:0]    retry_cnt_reg, retry_cnt_next;
  logic [TW-1:0]    to_cnt_reg, to_cnt_next;
  logic [DWIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [1:0]       rsp_status_reg, rsp_status_next;

  cmd_t             push_word;
  cmd_t             head;
  logic             fifo_pop;
  logic             fifo_not_full;
  logic             fifo_not_empty;
  logic             xfer_active;

  assign push_word.rnw  = cmd_rnw;
  assign push_word.addr = cmd_addr;
  assign push_word.data = cmd_data;
  assign push_word.be   = cmd_be;

  opb_cfg_seq_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .WIDTH (CMD_WIDTH)
  ) u_fifo (
    .clk       (OPB_Clk),
    .rst       (OPB_Rst),
    .push      (cmd_valid),
    .push_data (push_word),
    .pop       (fifo_pop),
    .head_data (head),
    .not_full  (fifo_not_full),
    .not_empty (fifo_not_empty)
  );

  always_comb begin
    state_next      = state_reg;
    retry_cnt_next  = retry_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    rsp_data_next   = rsp_data_reg;
    rsp_status_next = rsp_status_reg;
    fifo_pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fifo_not_empty) begin
          state_next     = ST_REQ;
          retry_cnt_next = '0;
        end
      end
      ST_REQ: begin
        if (OPB_MGrant) begin
          state_next  = ST_XFER;
          to_cnt_next = '0;
        end
      end
      ST_XFER: begin
        to_cnt_next = to_cnt_reg + TW'(1);
        // errAck outranks xferAck, which outranks retry, which outranks any timeout.
        if (OPB_errAck) begin
          state_next      = ST_RESP;
          fifo_pop        = 1'b1;
          rsp_status_next = STATUS_ERRACK;
          rsp_data_next   = '0;
        end else if (OPB_xferAck) begin
          state_next      = ST_RESP;
          fifo_pop        = 1'b1;
          rsp_status_next = STATUS_OK;
          rsp_data_next   = head.rnw ? OPB_DBus : '0;
        end else if (OPB_retry) begin
          if (retry_cnt_reg < RETRY_MAX) begin
            state_next     = ST_REQ;
            retry_cnt_next = retry_cnt_reg + RW'(1);
          end else begin
            state_next      = ST_RESP;
            fifo_pop        = 1'b1;
            rsp_status_next = STATUS_RETRY;
            rsp_data_next   = '0;
          end
        end else if (OPB_timeout || (to_cnt_reg == TO_LAST)) begin
          state_next      = ST_RESP;
          fifo_pop        = 1'b1;
          rsp_status_next = STATUS_TIMEOUT;
          rsp_data_next   = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_reg      <= ST_IDLE;
      retry_cnt_reg  <= '0;
      to_cnt_reg     <= '0;
      rsp_data_reg   <= '0;
      rsp_status_reg <= STATUS_OK;
    end else begin
      state_reg      <= state_next;
      retry_cnt_reg  <= retry_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_status_reg <= rsp_status_next;
    end
  end

  // Bus qualifiers decode straight from state so a reset drops them without waiting for a clock.
  assign xfer_active = (state_reg == ST_XFER);
  assign M_request   = (state_reg == ST_REQ);
  assign M_select    = xfer_active;
  assign M_RNW       = xfer_active & head.rnw;
  assign M_seqAddr   = 1'b0;

  // OPB numbers bit 0 as the MSB; everything not in XFER must stay 0 for the wired-OR bus.
  for (genvar gi = 0; gi < AWIDTH; gi++) begin : g_abus
    assign M_ABus[gi] = xfer_active & head.addr[AWIDTH-1-gi];
  end

  for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_dbus
    assign M_DBus[gi] = xfer_active & ~head.rnw & head.data[DWIDTH-1-gi];
  end

  for (genvar gi = 0; gi < BEWIDTH; gi++) begin : g_be
    assign M_BE[gi] = xfer_active & head.be[BEWIDTH-1-gi];
  end

  assign cmd_ready  = fifo_not_full;
  assign rsp_valid  = (state_reg == ST_RESP);
  assign rsp_data   = rsp_data_reg;
  assign rsp_status = rsp_status_reg;
  assign busy       = (state_reg != ST_IDLE) | fifo_not_empty;

endmodule

// File: tb/tb_opb_cfg_sequencer.sv
// Directed bench: a table of single-command transactions with a scripted slave,
// followed by latency, FIFO back-pressure and reset-during-transfer sequences.
module tb_opb_cfg_sequencer;

  localparam int K_ACK      = 0;
  localparam int K_ERRACK   = 1;
  localparam int K_RETRY    = 2;
  localparam int K_NONE     = 3;
  localparam int K_OPBTO    = 4;
  localparam int K_RETRY1   = 5;
  localparam int K_ACKRETRY = 6;
  localparam int NVEC       = 8;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    int          kind;
    int          ack_cyc;
    logic [1:0]  exp_st;
    logic [31:0] exp_data;
    int          exp_xfer;
    int          exp_req;
  } vec_t;

  logic        OPB_Clk;
  logic        OPB_Rst;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        M_request, M_select, M_RNW, M_seqAddr;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
  logic [0:31] OPB_DBus;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [NVEC];

  opb_cfg_sequencer #(
    .C_FIFO_DEPTH (4),
    .C_TIMEOUT    (16),
    .C_MAX_RETRY  (3)
  ) dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst     (OPB_Rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rnw     (cmd_rnw),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_be      (cmd_be),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .busy        (busy),
    .M_request   (M_request),
    .M_select    (M_select),
    .M_RNW       (M_RNW),
    .M_seqAddr   (M_seqAddr),
    .M_ABus      (M_ABus),
    .M_DBus      (M_DBus),
    .M_BE        (M_BE),
    .OPB_MGrant  (OPB_MGrant),
    .OPB_xferAck (OPB_xferAck),
    .OPB_errAck  (OPB_errAck),
    .OPB_retry   (OPB_retry),
    .OPB_timeout (OPB_timeout),
    .OPB_DBus    (OPB_DBus)
  );

  initial begin
    OPB_Clk = 1'b0;
    forever #5 OPB_Clk = ~OPB_Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic slave_quiet();
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_timeout = 1'b0;
    OPB_DBus    = '0;
  endtask

  task automatic push_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input string name);
    @(negedge OPB_Clk);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_be    = be;
    for (int n = 0; n < 50 && !cmd_ready; n++) @(negedge OPB_Clk);
    chk(name, cmd_ready, 1'b1);
    @(posedge OPB_Clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] bp_addr(input int i);
    return 32'h0000_1000 + 32'(i * 4);
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int          xfer_n, req_n, cyc, att;
    bit          bus_bad, prev_req, done;
    logic [31:0] d0;
    logic [1:0]  s0;
    xfer_n = 0; req_n = 0; cyc = 0; att = 0;
    bus_bad = 0; prev_req = 0; done = 0;
    d0 = '0; s0 = '0;
    push_cmd(v.rnw, v.addr, v.wdata, v.be, $sformatf("v%0d_push", idx));
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge OPB_Clk);
      slave_quiet();
      if (M_request && !prev_req) req_n++;
      prev_req = M_request;
      if (M_select) begin
        if (cyc == 0) att++;
        cyc++;
        xfer_n++;
        if (M_ABus !== v.addr || M_RNW !== v.rnw || M_BE !== v.be || M_seqAddr !== 1'b0 ||
            M_DBus !== (v.rnw ? 32'h0 : v.wdata)) bus_bad = 1;
        case (v.kind)
          K_ACK: if (cyc == v.ack_cyc) begin
            OPB_xferAck = 1'b1;
            OPB_DBus    = v.rnw ? v.rdata : 32'h0;
          end
          K_ERRACK: if (cyc == v.ack_cyc) begin
            OPB_errAck  = 1'b1;
            OPB_xferAck = 1'b1;
            OPB_DBus    = v.rdata;
          end
          K_RETRY: if (cyc == 1) OPB_retry = 1'b1;
          K_OPBTO: if (cyc == v.ack_cyc) OPB_timeout = 1'b1;
          K_RETRY1: begin
            if (att == 1 && cyc == 1) OPB_retry = 1'b1;
            else if (att >= 2 && cyc == v.ack_cyc) begin
              OPB_xferAck = 1'b1;
              OPB_DBus    = v.rdata;
            end
          end
          K_ACKRETRY: if (cyc == v.ack_cyc) begin
            OPB_xferAck = 1'b1;
            OPB_retry   = 1'b1;
            OPB_DBus    = v.rdata;
          end
          default: ;
        endcase
      end else begin
        cyc = 0;
        if (M_ABus !== 32'h0 || M_DBus !== 32'h0 || M_BE !== 4'h0 || M_RNW !== 1'b0) bus_bad = 1;
      end
      if (rsp_valid) begin
        done = 1;
        d0   = rsp_data;
        s0   = rsp_status;
      end
    end
    chk($sformatf("v%0d_rsp_seen", idx), done, 1'b1);
    chk($sformatf("v%0d_status", idx), s0, v.exp_st);
    chk($sformatf("v%0d_data", idx), d0, v.exp_data);
    chk($sformatf("v%0d_xfer_cycles", idx), xfer_n, v.exp_xfer);
    chk($sformatf("v%0d_req_phases", idx), req_n, v.exp_req);
    chk($sformatf("v%0d_bus_values", idx), bus_bad, 1'b0);
    chk($sformatf("v%0d_busy_in_resp", idx), busy, 1'b1);
    @(negedge OPB_Clk);
    chk($sformatf("v%0d_hold_valid", idx), rsp_valid, 1'b1);
    chk($sformatf("v%0d_hold_data", idx), rsp_data, v.exp_data);
    chk($sformatf("v%0d_hold_status", idx), rsp_status, v.exp_st);
    rsp_ready = 1'b1;
    @(negedge OPB_Clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_valid_after_hs", idx), rsp_valid, 1'b0);
    chk($sformatf("v%0d_idle_after_hs", idx), busy, 1'b0);
    $display("vec %0d addr=%h status=%0d data=%h xfer=%0d req=%0d", idx, v.addr, s0, d0, xfer_n, req_n);
  endtask

  initial begin
    int  first_req, first_sel, sel_cycles, nrsp;
    bit  early, fifth_go, fifth_at_rsp, order_bad, stray;

    vecs[0] = '{1'b0, 32'h0100_3700, 32'h0000_0001, 32'h0,         4'hF, K_ACK,      2, 2'b00, 32'h0,         2,  1};
    vecs[1] = '{1'b1, 32'h0100_3704, 32'h0,         32'hDEAD_BEEF, 4'hF, K_ACK,      1, 2'b00, 32'hDEAD_BEEF, 1,  1};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,         4'h3, K_RETRY,    1, 2'b11, 32'h0,         4,  4};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'h0,         32'h1234_0000, 4'hF, K_NONE,     1, 2'b10, 32'h0,         16, 1};
    vecs[4] = '{1'b0, 32'h0000_0030, 32'h1234_5678, 32'h5555_5555, 4'hC, K_ERRACK,   2, 2'b01, 32'h0,         2,  1};
    vecs[5] = '{1'b1, 32'h0000_0040, 32'h0,         32'h7777_7777, 4'hF, K_OPBTO,    3, 2'b10, 32'h0,         3,  1};
    vecs[6] = '{1'b1, 32'h0000_0044, 32'h0,         32'h0BAD_F00D, 4'h1, K_RETRY1,   1, 2'b00, 32'h0BAD_F00D, 2,  2};
    vecs[7] = '{1'b1, 32'h0000_0048, 32'h0,         32'hCAFE_F00D, 4'h8, K_ACKRETRY, 1, 2'b00, 32'hCAFE_F00D, 1,  1};

    OPB_Rst    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_rnw    = 1'b0;
    cmd_addr   = '0;
    cmd_data   = '0;
    cmd_be     = '0;
    rsp_ready  = 1'b0;
    OPB_MGrant = 1'b0;
    slave_quiet();

    // Reset state
    repeat (3) @(negedge OPB_Clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_select", M_select, 1'b0);
    chk("rst_m_request", M_request, 1'b0);
    chk("rst_m_abus", M_ABus, 32'h0);
    chk("rst_rsp_status", rsp_status, 2'b00);
    chk("rst_rsp_data", rsp_data, 32'h0);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    $display("reset: cmd_ready=%0d after release", cmd_ready);

    // Command to M_select latency with grant tied high
    OPB_MGrant = 1'b1;
    rsp_ready  = 1'b1;
    first_req = 0; first_sel = 0; sel_cycles = 0;
    push_cmd(1'b0, 32'h0000_0100, 32'h0000_00AA, 4'hF, "lat_push");
    for (int n = 1; n <= 12; n++) begin
      @(negedge OPB_Clk);
      slave_quiet();
      if (M_request && first_req == 0) first_req = n;
      if (M_select && first_sel == 0) first_sel = n;
      if (M_select) begin
        sel_cycles++;
        OPB_xferAck = 1'b1;
      end
    end
    slave_quiet();
    rsp_ready = 1'b0;
    chk("lat_request_cycle", first_req, 2);
    chk("lat_select_cycle", first_sel, 3);
    chk("lat_select_len", sel_cycles, 1);
    chk("lat_idle_after", busy, 1'b0);
    $display("latency: request@%0d select@%0d", first_req, first_sel);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // FIFO back-pressure: four queued reads block the fifth until the first response
    OPB_MGrant = 1'b0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, bp_addr(i), 32'h0, 4'hF, $sformatf("bp_push%0d", i));
    @(negedge OPB_Clk);
    chk("bp_full_ready", cmd_ready, 1'b0);
    chk("bp_request", M_request, 1'b1);
    cmd_valid = 1'b1;
    cmd_rnw   = 1'b1;
    cmd_addr  = bp_addr(4);
    cmd_data  = '0;
    cmd_be    = 4'hF;
    early = 0;
    repeat (4) begin
      @(negedge OPB_Clk);
      if (cmd_ready) early = 1;
    end
    chk("bp_hold_off", early, 1'b0);
    OPB_MGrant = 1'b1;
    rsp_ready  = 1'b1;
    nrsp = 0; fifth_go = 0; fifth_at_rsp = 0; order_bad = 0;
    for (int n = 0; n < 100 && nrsp < 5; n++) begin
      @(negedge OPB_Clk);
      slave_quiet();
      if (fifth_go) begin
        cmd_valid = 1'b0;
        fifth_go  = 0;
      end else if (cmd_valid && cmd_ready) begin
        fifth_go     = 1;
        fifth_at_rsp = rsp_valid;
      end
      if (rsp_valid) begin
        if (rsp_data !== ~bp_addr(nrsp) || rsp_status !== 2'b00) order_bad = 1;
        nrsp++;
      end
      if (M_select) begin
        OPB_xferAck = 1'b1;
        OPB_DBus    = ~M_ABus;
      end
    end
    slave_quiet();
    cmd_valid = 1'b0;
    chk("bp_fifth_on_handshake", fifth_at_rsp, 1'b1);
    chk("bp_rsp_count", nrsp, 5);
    chk("bp_rsp_order", order_bad, 1'b0);
    @(negedge OPB_Clk);
    rsp_ready = 1'b0;
    chk("bp_drained", busy, 1'b0);
    $display("backpressure: responses=%0d fifth_on_handshake=%0d", nrsp, fifth_at_rsp);

    // Reset in the middle of a transfer with commands still queued
    OPB_MGrant = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 32'h0000_2000 + 32'(i), 32'h1, 4'hF, $sformatf("rx_push%0d", i));
    for (int n = 0; n < 20 && !M_select; n++) @(negedge OPB_Clk);
    chk("rx_in_xfer", M_select, 1'b1);
    #2;
    OPB_Rst = 1'b1;
    #1;
    chk("rx_select_drop", M_select, 1'b0);
    chk("rx_abus_drop", M_ABus, 32'h0);
    chk("rx_busy", busy, 1'b0);
    chk("rx_cmd_ready", cmd_ready, 1'b0);
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    stray = 0;
    repeat (30) begin
      @(negedge OPB_Clk);
      if (rsp_valid || M_request || M_select || busy) stray = 1;
    end
    chk("rx_no_activity", stray, 1'b0);
    chk("rx_ready_after", cmd_ready, 1'b1);
    $display("reset mid-xfer: stray_activity=%0d", stray);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opb_cfg_sequencer.md
OPB_CFG_SEQUENCER -- requirements
Module: opb_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter C_FIFO_DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-002 The block SHALL have parameter C_TIMEOUT, default 16, OPB_Clk cycles allowed in XFER before local timeout.
REQ-003 The block SHALL have parameter C_MAX_RETRY, default 3, maximum retries per command.
REQ-004 The block SHALL have these ports:
- OPB_Clk  in  1  sole clock; all logic on its rising edge.
- OPB_Rst  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_rnw  in  1  1=read, 0=write.
- cmd_addr  in  32  absolute OPB address.
- cmd_data  in  32  write data (ignored for reads).
- cmd_be  in  4  byte enables.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_data  out  32  read data; 0 for writes.
- rsp_status  out  2  00 ok, 01 errAck, 10 timeout, 11 retries exhausted.
- busy  out  1  high when FSM is not IDLE or the FIFO is non-empty.
- M_request  out  1  OPB bus request.
- M_select, M_RNW, M_seqAddr  out  1 each  OPB master qualifiers.
- M_ABus, M_DBus  out  [0:31]  OPB address/data.
- M_BE  out  [0:3]  OPB byte enables.
- OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout  in  1 each  arbiter/slave responses.
- OPB_DBus  in  [0:31]  OPB read data.

Function
REQ-005 A command SHALL be pushed when cmd_valid and cmd_ready are both high; cmd_ready SHALL equal the registered FIFO not-full flag.
REQ-006 The FSM SHALL have states IDLE, REQ, XFER and RESP.
REQ-007 IDLE->REQ SHALL occur when the FIFO is non-empty; M_request SHALL be high only in REQ.
REQ-008 REQ->XFER SHALL occur the cycle after OPB_MGrant is sampled high in REQ.
REQ-009 In XFER, M_select=1, M_seqAddr=0, and M_ABus/M_DBus/M_BE/M_RNW SHALL carry the FIFO head (M_DBus=0 for reads).
REQ-010 Outside XFER, M_select, M_RNW, M_ABus, M_DBus and M_BE SHALL all be 0 (wired-OR bus rule).
REQ-011 XFER exit priority, highest first: OPB_errAck -> RESP, status 01; OPB_xferAck -> RESP, status 00, rsp_data=OPB_DBus if read; OPB_retry -> see REQ-012; OPB_timeout or local count = C_TIMEOUT-1 -> RESP, status 10.
REQ-012 On retry: if retry_cnt < C_MAX_RETRY, increment retry_cnt and go to REQ; otherwise go to RESP with status 11.
REQ-013 The FIFO head SHALL be popped on every entry to RESP; retry_cnt and the timeout counter SHALL clear on each entry to XFER from IDLE/REQ as appropriate (timeout per attempt, retry per command).
REQ-014 In RESP, rsp_valid=1 and rsp_data/rsp_status SHALL be held stable until rsp_ready=1; then the FSM goes to IDLE.
REQ-015 A push while the FSM is in any state SHALL be accepted if not full; push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-016 FIFO pointers SHALL wrap modulo C_FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-017 Command-to-M_select latency SHALL be 3 cycles with OPB_MGrant tied high and the FIFO empty.

Reset
REQ-018 OPB_Rst SHALL asynchronously force: IDLE, FIFO empty, all counters 0, M_* = 0, rsp_valid=0, rsp_data=0, rsp_status=00, cmd_ready=0 while asserted and 1 in the first cycle after release.
REQ-019 Reset mid-XFER SHALL drop M_select immediately and discard all queued commands without a response.

Structure
REQ-020 Package opb_cfg_seq_pkg SHALL hold the state enum, the status code constants, and the OPB width constants (AWIDTH=32, DWIDTH=32, BEWIDTH=4).
REQ-021 The FIFO SHALL be sub-module opb_cfg_seq_fifo (synchronous, same clock/reset, data width 69).

Verification
REQ-022 Write 0x01003700<-0x00000001, BE=0xF, grant tied high, xferAck on the 2nd XFER cycle -> one M_select pulse of 2 cycles, rsp_status=00, rsp_data=0.
REQ-023 Read 0x01003704, slave returns 0xDEADBEEF with xferAck -> rsp_data=0xDEADBEEF, status 00.
REQ-024 Slave asserts OPB_retry on 4 consecutive attempts -> 4 REQ phases, then status 11, FIFO popped.
REQ-025 No slave response -> RESP after exactly 16 XFER cycles, status 10; errAck together with xferAck -> status 01.
REQ-026 Push 5 commands with rsp_ready=0 -> cmd_ready low after 4 pushes, and the 5th is accepted only after the first response handshake.
REQ-027 Assert OPB_Rst during XFER -> M_select=0 in the same cycle, busy=0, no rsp_valid after release.
